// File: rtl/ws2812b_decoder.sv
// WS2812B serial line decoder: measures high pulse widths on a synchronized din to recover 24-bit GRB pixels and frame boundaries.
// Latency: pixel_valid, frame_done and boundary err are registered 3 clk edges after the relevant din falling edge.
// Backpressure: none; the serial line cannot be stalled, so every strobe is a single-cycle pulse that must be sampled immediately.
module ws2812b_decoder #(
  parameter int BIT_THRESH   = 7,
  parameter int MIN_HIGH     = 2,
  parameter int MAX_HIGH     = 20,
  parameter int RESET_CYCLES = 600,
  parameter int NUM_PIXELS   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [5:0]  pixel_index,
  output logic        frame_done,
  output logic [6:0]  pixel_count,
  output logic        err
);

  localparam int LOW_W = $clog2(RESET_CYCLES + 1);

  localparam logic [15:0]      THRESH_C = 16'(BIT_THRESH);
  localparam logic [15:0]      MIN_C    = 16'(MIN_HIGH);
  localparam logic [15:0]      MAX_C    = 16'(MAX_HIGH);
  localparam logic [LOW_W-1:0] RST_M1_C = LOW_W'(RESET_CYCLES - 1);
  localparam logic [LOW_W-1:0] LOW_ONE  = LOW_W'(1);
  localparam logic [6:0]       NUM_PIX_C = 7'(NUM_PIXELS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t state, state_nxt;

  logic din_meta, din_s;

  logic [15:0]      high_cnt, high_cnt_nxt;
  logic [LOW_W-1:0] low_cnt, low_cnt_nxt;
  logic [4:0]       bit_cnt, bit_cnt_nxt, bit_cnt_inc;
  logic [6:0]       pix_cnt, pix_cnt_nxt;
  logic [23:0]      shift_reg, shift_nxt;

  logic [23:0] pixel_data_nxt;
  logic [5:0]  pixel_index_nxt;
  logic [6:0]  pixel_count_nxt;
  logic        pixel_valid_nxt, frame_done_nxt, err_nxt;
  logic        bit_val;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_nxt;
  end

  // Next-state, counter and output-strobe logic for the pulse-width decoder.
  always_comb begin
    state_nxt       = state;
    high_cnt_nxt    = high_cnt;
    low_cnt_nxt     = low_cnt;
    bit_cnt_nxt     = bit_cnt;
    pix_cnt_nxt     = pix_cnt;
    shift_nxt       = shift_reg;
    pixel_data_nxt  = pixel_data;
    pixel_index_nxt = pixel_index;
    pixel_count_nxt = pixel_count;
    pixel_valid_nxt = 1'b0;
    frame_done_nxt  = 1'b0;
    err_nxt         = 1'b0;
    bit_val         = 1'b0;
    bit_cnt_inc     = bit_cnt + 5'd1;

    unique case (state)
      SYNC: begin
        // Any high restarts the search for a full reset-length low period.
        if (din_s) begin
          low_cnt_nxt = '0;
        end else if (low_cnt >= RST_M1_C) begin
          low_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          pix_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          low_cnt_nxt = low_cnt + LOW_ONE;
        end
      end

      IDLE: begin
        if (din_s) begin
          high_cnt_nxt = 16'd1;
          bit_cnt_nxt  = '0;
          state_nxt    = HIGH;
        end
      end

      HIGH: begin
        if (high_cnt > MAX_C) begin
          // Stuck-high line: drop the partial pixel and resynchronize.
          err_nxt     = 1'b1;
          bit_cnt_nxt = '0;
          pix_cnt_nxt = '0;
          low_cnt_nxt = '0;
          state_nxt   = SYNC;
        end else if (din_s) begin
          if (high_cnt != 16'hFFFF) high_cnt_nxt = high_cnt + 16'd1;
        end else if (high_cnt < MIN_C) begin
          // Glitch too short to be a bit.
          err_nxt     = 1'b1;
          bit_cnt_nxt = '0;
          pix_cnt_nxt = '0;
          low_cnt_nxt = '0;
          state_nxt   = SYNC;
        end else begin
          bit_val     = (high_cnt >= THRESH_C);
          shift_nxt   = {shift_reg[22:0], bit_val};
          low_cnt_nxt = LOW_ONE;
          state_nxt   = LOW;
          if (bit_cnt_inc == 5'd24) begin
            bit_cnt_nxt = '0;
            if (pix_cnt < NUM_PIX_C) begin
              pixel_data_nxt  = shift_nxt;
              pixel_index_nxt = pix_cnt[5:0];
              pixel_valid_nxt = 1'b1;
              pix_cnt_nxt     = pix_cnt + 7'd1;
            end else begin
              // Frame overrun: the extra pixel is reported but not emitted.
              err_nxt = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt_inc;
          end
        end
      end

      LOW: begin
        if (din_s) begin
          high_cnt_nxt = 16'd1;
          state_nxt    = HIGH;
        end else if (low_cnt >= RST_M1_C) begin
          // Latch period reached: close the frame.
          if (bit_cnt != 5'd0) begin
            err_nxt = 1'b1;
          end else if (pix_cnt != 7'd0) begin
            frame_done_nxt  = 1'b1;
            pixel_count_nxt = pix_cnt;
          end
          pix_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          low_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          low_cnt_nxt = low_cnt + LOW_ONE;
        end
      end

      default: state_nxt = SYNC;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      shift_reg   <= '0;
      pixel_data  <= '0;
      pixel_index <= '0;
      pixel_count <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      high_cnt    <= high_cnt_nxt;
      low_cnt     <= low_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      pix_cnt     <= pix_cnt_nxt;
      shift_reg   <= shift_nxt;
      pixel_data  <= pixel_data_nxt;
      pixel_index <= pixel_index_nxt;
      pixel_count <= pixel_count_nxt;
      pixel_valid <= pixel_valid_nxt;
      frame_done  <= frame_done_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: doc/ws2812b_decoder.md
WS2812B_DECODER -- requirements
Module: ws2812b_decoder

Interface
REQ-001 Parameter BIT_THRESH, default 7: measured high time in clk cycles at or above which a bit decodes as 1; below it, as 0.
REQ-002 Parameter MIN_HIGH, default 2: high times below this are glitches.
REQ-003 Parameter MAX_HIGH, default 20: high times above this are stuck-high faults.
REQ-004 Parameter RESET_CYCLES, default 600: low time in clk cycles that marks a latch/frame boundary (50 us at 12 MHz).
REQ-005 Parameter NUM_PIXELS, default 64: pixels per frame (8x8 matrix).
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 din  input  1  WS2812B serial line, asynchronous to clk.
REQ-009 pixel_data  output  24  last decoded pixel, GRB order, first-received bit in [23].
REQ-010 pixel_valid  output  1  one-cycle strobe; pixel_data and pixel_index are valid this cycle.
REQ-011 pixel_index  output  6  position of the pixel within the current frame, 0-based.
REQ-012 frame_done  output  1  one-cycle strobe at a frame boundary that ended a non-empty, well-formed frame.
REQ-013 pixel_count  output  7  number of pixels in the frame; valid while frame_done is high.
REQ-014 err  output  1  one-cycle strobe on any protocol fault.

Function
REQ-015 din shall pass through a 2-flop synchronizer; all decoding shall use only the synchronized signal din_s.
REQ-016 The FSM shall have states SYNC, IDLE, HIGH and LOW.
REQ-017 SYNC: wait for din_s low for RESET_CYCLES consecutive cycles, then go to IDLE; no outputs are produced from SYNC.
REQ-018 IDLE: when din_s=1, go to HIGH with high_cnt=1 and bit_cnt=0.
REQ-019 HIGH: increment high_cnt (16-bit, saturating) while din_s=1.
REQ-020 HIGH with high_cnt>MAX_HIGH: pulse err, discard the partial pixel, go to SYNC.
REQ-021 HIGH when din_s=0 with high_cnt<MIN_HIGH: pulse err, discard the partial pixel, go to SYNC.
REQ-022 HIGH when din_s=0 otherwise: shift bit (high_cnt>=BIT_THRESH) into a 24-bit shift register MSB-first, increment bit_cnt, go to LOW with low_cnt=1.
REQ-023 When bit_cnt reaches 24 and pix_cnt<NUM_PIXELS: register pixel_data, pixel_index=pix_cnt, pulse pixel_valid, increment pix_cnt, clear bit_cnt.
REQ-024 When bit_cnt reaches 24 and pix_cnt=NUM_PIXELS: pulse err, emit no pixel, clear bit_cnt, leave pix_cnt unchanged; decoding continues until the boundary.
REQ-025 LOW when din_s=1: go to HIGH with high_cnt=1.
REQ-026 LOW when low_cnt reaches RESET_CYCLES: evaluate the boundary; after evaluation clear pix_cnt and bit_cnt and go to IDLE.
REQ-027 Boundary with bit_cnt=0 and pix_cnt>0: pulse frame_done with pixel_count=pix_cnt.
REQ-028 Boundary with bit_cnt!=0: pulse err instead of frame_done.
REQ-029 Latency: pixel_valid shall rise on the 3rd rising clk edge after the din falling edge of a pixel's 24th bit; frame_done and boundary err follow the same 3-edge synchronizer+register rule.
REQ-030 All strobes shall be exactly one cycle wide.
REQ-031 err and pixel_valid/frame_done are never asserted in the same cycle.
REQ-032 pixel_data shall hold its value until the next pixel_valid.
REQ-033 Width rules: pix_cnt is 7 bits; low_cnt is wide enough for RESET_CYCLES and saturates at it; bit_cnt is 5 bits.

Reset
REQ-034 While rst_n=0: all outputs 0, state SYNC, all counters and the shift register 0, synchronizer flops 0.
REQ-035 Reset asserted mid-pixel or mid-frame shall abandon all partial data without err.
REQ-036 After release, a full RESET_CYCLES low period is required before any pixel is decoded.

Verification
REQ-037 After reset, 600 low cycles, then one pixel 0xFF0055 with 4-cycle 0-bits and 10-cycle 1-bits (12-cycle periods), then 600 low -> pixel_valid once with data 0xFF0055 and index 0, then frame_done with pixel_count=1.
REQ-038 Full 64-pixel frame of incrementing GRB values, then boundary -> 64 pixel_valid strobes with indices 0..63 and matching data; frame_done with pixel_count=64; err never asserted.
REQ-039 65 pixels in one frame -> 64 pixel_valid strobes; err once at the 65th pixel; frame_done with pixel_count=64.
REQ-040 12 bits followed by 600 low -> err once; no pixel_valid, no frame_done; the next well-formed frame decodes with index starting at 0.
REQ-041 1-cycle high glitch mid-pixel, then a 30-cycle high -> err at the glitch; no outputs until 600 low cycles; subsequent frame decodes correctly.
REQ-042 rst_n pulsed low during the 10th pixel -> outputs 0 immediately, no err; pixels decode only after a fresh 600-cycle low period.
